// File: rtl/aud_pkg.sv
// Shared types and constants for the audio recorder slice.
// Optional build macro: AUD_REC_MONO_MIX_EN (mono mix of left and right channels).
package aud_pkg;

  // Recorder control states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_DELAY  = 3'd2,
    S_SHIFT  = 3'd3,
    S_WRITE  = 3'd4,
    S_PAUSED = 3'd5
  } state_t;

  // Default sample and SRAM word-address widths
  localparam int AUD_DATA_W = 16;
  localparam int AUD_ADDR_W = 20;

  // ADCLRCK level that marks the left channel slot
  localparam logic LRC_LEFT = 1'b0;

endpackage

// File: rtl/aud_recorder_i2s_shift_rx.sv
// I2S serial-to-parallel receiver: shifts DATA_W bits MSB first while enabled
// and raises a one-cycle done pulse on the cycle after the last bit lands.
// The bit counter restarts whenever i_clr is held, so one instance can be
// reused for consecutive channel slots.
module i2s_shift_rx
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_dat,
  output logic [DATA_W-1:0] o_data,
  output logic              o_done
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  cnt;

  // Shift register, bit counter and done pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift  <= '0;
      cnt    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_clr) begin
        cnt <= '0;
      end else if (i_en) begin
        shift <= {shift[DATA_W-2:0], i_dat};
        if (cnt == CNT_LAST) begin
          cnt    <= '0;
          o_done <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

  assign o_data = shift;

endmodule

// File: rtl/aud_recorder.sv
// Audio recorder: captures I2S ADC samples on the codec BCLK and emits one
// word per LRC frame to the SRAM writer with an incrementing address.
// Optional build macro: AUD_REC_MONO_MIX_EN -- when defined, the left and
// right slots are both captured and their signed average is written;
// otherwise only the left slot is recorded.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int                DATA_W   = AUD_DATA_W,
  parameter int                ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_done,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_dat,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_recording,
  output logic              o_paused,
  output logic              o_full
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic              init_seen;
  logic              lrc_d;
  logic              pause_pending;
  logic              right_phase;
  logic [ADDR_W-1:0] address;

  logic              init_ok;
  logic              lrc_fall;
  logic              lrc_rise;
  logic              slot_edge;
  logic              shift_en;
  logic              shift_clr;
  logic              shift_done;
  logic [DATA_W-1:0] shift_data;
  logic [DATA_W-1:0] sample;

  // A start in the same cycle as the init pulse is already allowed
  assign init_ok   = init_seen | i_init_done;
  // Slot boundaries: falling LRC opens the left slot, rising opens the right
  assign lrc_fall  = (lrc_d != LRC_LEFT) && (i_lrc == LRC_LEFT);
  assign lrc_rise  = (lrc_d == LRC_LEFT) && (i_lrc != LRC_LEFT);
  assign slot_edge = right_phase ? lrc_rise : lrc_fall;
  // The receiver only runs in SHIFT and stops as soon as it reports done
  assign shift_en  = (state == S_SHIFT) && !shift_done;
  assign shift_clr = (state != S_SHIFT);

`ifdef AUD_REC_MONO_MIX_EN
  logic [DATA_W-1:0] left_sample;
  logic [DATA_W:0]   mix_sum;

  // Sign-extended sum; dropping the LSB is an arithmetic shift right by one
  assign mix_sum = {left_sample[DATA_W-1], left_sample} + {shift_data[DATA_W-1], shift_data};
  assign sample  = mix_sum[DATA_W:1];
`else
  assign sample  = shift_data;
`endif

  i2s_shift_rx #(
    .DATA_W (DATA_W)
  ) u_shift_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (shift_en),
    .i_clr   (shift_clr),
    .i_dat   (i_dat),
    .o_data  (shift_data),
    .o_done  (shift_done)
  );

  // Recorder FSM with registered write strobe, data, address and status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      init_seen     <= 1'b0;
      lrc_d         <= 1'b0;
      pause_pending <= 1'b0;
      right_phase   <= 1'b0;
      address       <= '0;
      o_valid       <= 1'b0;
      o_data        <= '0;
      o_address     <= '0;
      o_end_addr    <= '0;
      o_recording   <= 1'b0;
      o_paused      <= 1'b0;
      o_full        <= 1'b0;
`ifdef AUD_REC_MONO_MIX_EN
      left_sample   <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      lrc_d   <= i_lrc;
      if (i_init_done) begin
        init_seen <= 1'b1;
      end

      // A strobe already issued in WRITE is committed whatever happens next
      if (state == S_WRITE) begin
        address    <= address + ADDR_ONE;
        o_end_addr <= o_end_addr + ADDR_ONE;
        if (address == MAX_ADDR) begin
          o_full <= 1'b1;
        end
      end

      if (i_stop) begin
        state         <= S_IDLE;
        o_recording   <= 1'b0;
        o_paused      <= 1'b0;
        pause_pending <= 1'b0;
        right_phase   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start && !i_pause && init_ok) begin
              address     <= '0;
              o_end_addr  <= '0;
              o_full      <= 1'b0;
              state       <= S_ARMED;
              o_recording <= 1'b1;
            end
          end

          S_ARMED: begin
            if (i_pause && !right_phase) begin
              state       <= S_PAUSED;
              o_recording <= 1'b0;
              o_paused    <= 1'b1;
            end else begin
              // Waiting for the right slot means a sample is half done
              if (i_pause) begin
                pause_pending <= 1'b1;
              end
              if (slot_edge) begin
                state <= S_DELAY;
              end
            end
          end

          S_DELAY: begin
            if (i_pause && !right_phase) begin
              state       <= S_PAUSED;
              o_recording <= 1'b0;
              o_paused    <= 1'b1;
            end else begin
              if (i_pause) begin
                pause_pending <= 1'b1;
              end
              state <= S_SHIFT;
            end
          end

          S_SHIFT: begin
            if (i_pause) begin
              pause_pending <= 1'b1;
            end
            if (shift_done) begin
`ifdef AUD_REC_MONO_MIX_EN
              if (!right_phase) begin
                left_sample <= shift_data;
                right_phase <= 1'b1;
                state       <= S_ARMED;
              end else begin
                right_phase <= 1'b0;
                o_valid     <= 1'b1;
                o_data      <= sample;
                o_address   <= address;
                state       <= S_WRITE;
              end
`else
              o_valid   <= 1'b1;
              o_data    <= sample;
              o_address <= address;
              state     <= S_WRITE;
`endif
            end
          end

          S_WRITE: begin
            if (address == MAX_ADDR) begin
              state         <= S_IDLE;
              o_recording   <= 1'b0;
              pause_pending <= 1'b0;
            end else if (pause_pending || i_pause) begin
              state         <= S_PAUSED;
              o_recording   <= 1'b0;
              o_paused      <= 1'b1;
              pause_pending <= 1'b0;
            end else begin
              state <= S_ARMED;
            end
          end

          S_PAUSED: begin
            if (i_start && !i_pause) begin
              state       <= S_ARMED;
              o_recording <= 1'b1;
              o_paused    <= 1'b0;
            end
          end

          default: begin
            state       <= S_IDLE;
            o_recording <= 1'b0;
            o_paused    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
